// File: rtl/detect_window_counter.sv
// rtl/detect_window_counter.sv - turns a detector match level into events, counts them per window, flags alarm/overflow
module detect_window_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] last_count,
    output logic             window_done,
    output logic             alarm,
    output logic             overflow
);

    localparam int TW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] C_MAX  = '1;
    localparam logic [TW-1:0]    C_LAST = TW'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_THR  = CNT_W'(THRESH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic             r_det_prev;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_last_count;
    logic             r_window_done;
    logic             r_alarm;
    logic             r_overflow;

    logic             w_event;
    logic             w_sat;
    logic             w_win_end;
    logic [CNT_W-1:0] w_total;

    // A held-high level only counts on its rising edge, and only while enabled.
    assign w_event   = det_in & ~r_det_prev & enable;
    assign w_sat     = w_event && (r_count == C_MAX);
    assign w_win_end = (r_timer == C_LAST);
    assign w_total   = w_sat ? C_MAX : (r_count + CNT_W'(w_event));

    // Pause/run FSM, window timer, event counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_det_prev    <= 1'b0;
            r_count       <= '0;
            r_last_count  <= '0;
            r_window_done <= 1'b0;
            r_alarm       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // The edge detector keeps tracking through pauses and clears so a
            // level that stays high is never counted a second time.
            r_det_prev    <= det_in;
            r_window_done <= 1'b0;

            // The first enabled cycle already counts, so the state only records
            // whether we are mid-run; the window itself survives a pause.
            case (r_state)
                IDLE:    if (enable)  r_state <= RUN;
                RUN:     if (!enable) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (clear) begin
                r_timer      <= '0;
                r_count      <= '0;
                r_last_count <= '0;
                r_alarm      <= 1'b0;
                r_overflow   <= 1'b0;
            end else if (enable) begin
                if (w_sat) begin
                    r_overflow <= 1'b1;
                end
                if (w_win_end) begin
                    r_last_count  <= w_total;
                    r_window_done <= 1'b1;
                    if (w_total >= C_THR) begin
                        r_alarm <= 1'b1;
                    end
                    r_count <= '0;
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                    if (w_event && !w_sat) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    assign count       = r_count;
    assign last_count  = r_last_count;
    assign window_done = r_window_done;
    assign alarm       = r_alarm;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_detect_window_counter.sv
// tb/tb_detect_window_counter.sv - randomized check of detect_window_counter against a window-level reference model
module tb_detect_window_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic det_in = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;

    logic [7:0] a_count, a_last;
    logic       a_done, a_alarm, a_ovf;
    logic [1:0] b_count, b_last;
    logic       b_done, b_alarm, b_ovf;

    int checks = 0;
    int failures = 0;

    // Reference model: per-window event tally as a plain integer, clipped on output.
    int win_len [2] = '{16, 32};
    int max_v   [2] = '{255, 3};
    int m_ev    [2];
    int m_pos   [2];
    int m_last  [2];
    int m_done  [2];
    int m_alarm [2];
    int m_ovf   [2];
    int m_prev;

    always #5 clk = ~clk;

    detect_window_counter #(.CNT_W(8), .WIN_LEN(16), .THRESH(3)) u_dut (
        .clk(clk), .reset(reset), .det_in(det_in), .enable(enable), .clear(clear),
        .count(a_count), .last_count(a_last), .window_done(a_done),
        .alarm(a_alarm), .overflow(a_ovf)
    );

    detect_window_counter #(.CNT_W(2), .WIN_LEN(32), .THRESH(3)) u_sat (
        .clk(clk), .reset(reset), .det_in(det_in), .enable(enable), .clear(clear),
        .count(b_count), .last_count(b_last), .window_done(b_done),
        .alarm(b_alarm), .overflow(b_ovf)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int clip(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_step();
        int ev;
        ev = (det_in && !m_prev && enable) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ev[k] = 0; m_pos[k] = 0; m_last[k] = 0;
                m_done[k] = 0; m_alarm[k] = 0; m_ovf[k] = 0;
            end else begin
                m_done[k] = 0;
                if (clear) begin
                    m_ev[k] = 0; m_pos[k] = 0; m_last[k] = 0;
                    m_alarm[k] = 0; m_ovf[k] = 0;
                end else if (enable) begin
                    m_ev[k] += ev;
                    if (m_ev[k] > max_v[k]) m_ovf[k] = 1;
                    if (m_pos[k] == win_len[k] - 1) begin
                        m_last[k] = clip(m_ev[k], max_v[k]);
                        m_done[k] = 1;
                        if (m_last[k] >= 3) m_alarm[k] = 1;
                        m_ev[k] = 0;
                        m_pos[k] = 0;
                    end else begin
                        m_pos[k]++;
                    end
                end
            end
        end
        m_prev = reset ? 0 : int'(det_in);
    endtask

    task automatic compare_all();
        check("a_count", int'(a_count), clip(m_ev[0], max_v[0]));
        check("a_last",  int'(a_last),  m_last[0]);
        check("a_done",  int'(a_done),  m_done[0]);
        check("a_alarm", int'(a_alarm), m_alarm[0]);
        check("a_ovf",   int'(a_ovf),   m_ovf[0]);
        check("b_count", int'(b_count), clip(m_ev[1], max_v[1]));
        check("b_last",  int'(b_last),  m_last[1]);
        check("b_done",  int'(b_done),  m_done[1]);
        check("b_alarm", int'(b_alarm), m_alarm[1]);
        check("b_ovf",   int'(b_ovf),   m_ovf[1]);
    endtask

    task automatic cyc(input logic r, input logic en, input logic d, input logic c);
        @(negedge clk);
        reset = r; enable = en; det_in = d; clear = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        m_prev = 0;
        for (int k = 0; k < 2; k++) begin
            m_ev[k] = 0; m_pos[k] = 0; m_last[k] = 0;
            m_done[k] = 0; m_alarm[k] = 0; m_ovf[k] = 0;
        end

        // Reset, then disabled cycles with a toggling detector.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, logic'(i % 2), 0);

        // Basic window: single-cycle pulses at cycles 2, 6, 10.
        for (int i = 0; i < 16; i++) cyc(0, 1, (i == 2 || i == 6 || i == 10), 0);
        check("basic_last", int'(a_last), 3);
        check("basic_alarm", int'(a_alarm), 1);

        // Held level counted once, plus a rising edge on the final window cycle.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, ((i >= 3 && i <= 9) || i == 15), 0);
        check("held_last", int'(a_last), 2);
        check("held_alarm", int'(a_alarm), 0);

        // Pause mid-window: disabled pulses ignored, window resumes.
        for (int i = 0; i < 8; i++) cyc(0, 1, (i == 1), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, logic'(i % 2), 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        check("pause_done", int'(a_done), 1);
        check("pause_last", int'(a_last), 1);

        // Saturation on the narrow instance: isolated events across one 32-cycle window.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 1, (i % 4 == 1 && i < 20), 0);
        check("sat_last", int'(b_last), 3);
        check("sat_ovf", int'(b_ovf), 1);

        // Clear on the window-end cycle of a window that already raised alarm.
        for (int i = 0; i < 15; i++) cyc(0, 1, (i % 3 == 0), 0);
        cyc(0, 1, 1, 1);
        check("clr_done", int'(a_done), 0);
        check("clr_alarm", int'(a_alarm), 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, (i == 4), 0);
        check("clr_next_last", int'(a_last), 1);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 8),
                logic'($urandom_range(0, 1)),
                ($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
